// File: rtl/fetch_unit.sv
// fifo: small generic synchronous FIFO with flush; DEPTH must be a power of 2.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: push is dropped only when full without a simultaneous pop.
module fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_vld,
   input  logic [WIDTH-1:0]           in_dat,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [WIDTH-1:0]           out_dat,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign out_vld = (count != '0);
   assign out_dat = out_vld ? mem[rd_ptr] : '0;
   assign do_pop  = out_vld && out_rdy;
   assign do_push = in_vld && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= in_dat;
   end
endmodule

// fetch_unit: owns the PC, issues in-order imem fetches and buffers {pc, inst} toward decode.
// Latency: response to inst_valid is one cycle; redirect takes effect on the next request.
// Backpressure: requests are credit-limited so in-flight plus buffered never exceeds FIFO_DEPTH.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_target
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_entry_t;

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] fifo_count;
   logic [SW-1:0] credit_used;
   logic [31:0]   target_aligned;
   logic          req_fire;
   logic          push_vld;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;

   assign imem_addr      = fetch_pc;
   assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid = !rst && !redirect && (credit_used < SW'(FIFO_DEPTH));
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign target_aligned = redirect_target & ~32'h3;

   assign push_vld        = imem_rsp_valid && !redirect && (discard == '0);
   assign push_entry.pc   = rsp_pc;
   assign push_entry.word = imem_rsp_data;

   fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_inst_buf (
      .clk     (clk),
      .rst     (rst),
      .flush   (redirect),
      .in_vld  (push_vld),
      .in_dat  (push_entry),
      .out_vld (inst_valid),
      .out_rdy (inst_ready),
      .out_dat (head),
      .count   (fifo_count)
   );

   assign inst    = head.word;
   assign inst_pc = head.pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
         if (redirect) begin
            fetch_pc <= target_aligned;
            rsp_pc   <= target_aligned;
            // outstanding already covers earlier pending discards, so every
            // in-flight request not answered this cycle becomes wrong-path.
            discard  <= outstanding - CW'(imem_rsp_valid);
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (imem_rsp_valid) begin
               if (discard != '0) discard <= discard - CW'(1);
               else               rsp_pc  <= rsp_pc + 32'd4;
            end
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an epoch-tagged imem model feeds a scoreboard
// that a negedge monitor drains whenever decode consumes an instruction.
module tb_fetch_unit;
   localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
   localparam int          DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;

   fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .redirect        (redirect),
      .redirect_target (redirect_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   req_t        pend[$];
   exp_t        sb[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          n_acc = 0;
   int          rdy_pct = 100;
   int          irdy_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          prev_rst = 1'b0;
   logic [31:0] fpc = RPC;

   function automatic logic [31:0] mk_data(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input bit rst_i, input bit redir_i, input logic [31:0] tgt_i);
      bit   rsp_now;
      req_t h;
      @(posedge clk);
      #1;
      rst             = rst_i;
      redirect        = redir_i;
      redirect_target = tgt_i;
      imem_req_ready  = ($urandom_range(99) < rdy_pct);
      inst_ready      = ($urandom_range(99) < irdy_pct);
      rsp_now         = !rst_i && (pend.size() > 0) && (pend[0].due <= cyc);
      imem_rsp_valid  = rsp_now;
      imem_rsp_data   = rsp_now ? mk_data(pend[0].addr) : $urandom;
      #1;
      if (rst_i) begin
         chk("req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
         if (prev_rst) begin
            chk("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
            chk("reset_imem_addr", imem_addr, RPC);
            chk("reset_inst", inst, 32'd0);
            chk("reset_inst_pc", inst_pc, 32'd0);
         end
         pend.delete();
         sb.delete();
         fpc = RPC;
         epoch++;
      end else begin
         chk("imem_addr", imem_addr, fpc);
         chk("req_valid", {31'b0, imem_req_valid},
             {31'b0, (!redir_i && (pend.size() + sb.size() < DEPTH))});
         chk("inst_valid", {31'b0, inst_valid}, {31'b0, (sb.size() != 0)});
         if (rsp_now) begin
            h = pend.pop_front();
            if (h.epoch == epoch) sb.push_back('{h.addr, mk_data(h.addr)});
         end
         if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{fpc, epoch, cyc + $urandom_range(lat_max, lat_min)});
            fpc = fpc + 32'd4;
            n_acc++;
         end
         if (redir_i) begin
            sb.delete();
            epoch++;
            fpc = tgt_i & ~32'h3;
         end
      end
      prev_rst = rst_i;
      cyc++;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom);
   endtask

   task automatic rand_run(input int n);
      logic [31:0] tgt;
      bit          r;
      for (int i = 0; i < n; i++) begin
         r   = ($urandom_range(99) < 5);
         tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
         step(1'b0, r, tgt);
      end
   endtask

   // Monitor: every consumed head must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && !redirect && inst_valid && inst_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_empty: got inst_pc %h with nothing expected (cycle %0d)", inst_pc, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("inst_pc", inst_pc, mon_e.pc);
            chk("inst", inst, mon_e.data);
         end
      end
   end

   initial begin
      // streaming from a reset PC that wraps past 2^32
      do_reset();
      run(20);

      // decode stalled: credit limit caps requests at DEPTH
      do_reset();
      irdy_pct = 0;
      n_acc    = 0;
      run(10);
      chk("stall_accepts", n_acc, DEPTH);
      irdy_pct = 100;
      run(10);

      // redirect with two requests in flight, long imem latency
      do_reset();
      lat_min = 4;
      lat_max = 4;
      run(2);
      step(1'b0, 1'b1, 32'h0000_0103);
      run(15);

      // redirect coinciding with a response while another is in flight
      do_reset();
      lat_min = 2;
      lat_max = 2;
      run(2);
      step(1'b0, 1'b1, 32'h0000_0040);
      run(10);

      // random traffic with a mid-stream reset
      rdy_pct  = 70;
      irdy_pct = 70;
      lat_min  = 1;
      lat_max  = 4;
      rand_run(1500);
      do_reset();
      rand_run(1500);

      rdy_pct  = 100;
      irdy_pct = 100;
      run(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
